// File: rtl/gpr_write_arbiter_if.sv
// Requester handshakes, register-file write port and status outputs of the
// GPR write arbiter, bundled so the arbiter and its users share one definition.
interface gpr_write_arbiter_if #(
  parameter int unsigned DROP_CNT_W = 8
);
  logic                  i_req0_valid;
  logic [4:0]            i_req0_reg;
  logic [31:0]           i_req0_data;
  logic                  o_req0_ready;
  logic                  i_req1_valid;
  logic [4:0]            i_req1_reg;
  logic [31:0]           i_req1_data;
  logic                  o_req1_ready;
  logic                  o_write_enable;
  logic [4:0]            o_write_reg;
  logic [31:0]           o_write_data;
  logic                  o_init_busy;
  logic                  o_last_grant;
  logic [DROP_CNT_W-1:0] o_drop_count;

  // Arbiter side
  modport slave (
    input  i_req0_valid, i_req0_reg, i_req0_data,
    input  i_req1_valid, i_req1_reg, i_req1_data,
    output o_req0_ready, o_req1_ready,
    output o_write_enable, o_write_reg, o_write_data,
    output o_init_busy, o_last_grant, o_drop_count
  );

  // Requester / environment side
  modport master (
    output i_req0_valid, i_req0_reg, i_req0_data,
    output i_req1_valid, i_req1_reg, i_req1_data,
    input  o_req0_ready, o_req1_ready,
    input  o_write_enable, o_write_reg, o_write_data,
    input  o_init_busy, o_last_grant, o_drop_count
  );
endinterface

// File: rtl/gpr_write_arbiter.sv
// Shares the GPR file write port between two writeback requesters.
// After reset it optionally writes INIT_VALUE to r1..r31, then arbitrates
// round-robin; writes to r0 are accepted, discarded and counted.
module gpr_write_arbiter #(
  parameter bit              INIT_ENABLE = 1'b1,
  parameter logic [31:0]     INIT_VALUE  = 32'h0000_0000,
  parameter int unsigned     DROP_CNT_W  = 8
) (
  input  logic               clock,
  input  logic               reset,
  gpr_write_arbiter_if.slave bus
);

  typedef enum logic {
    ST_INIT,
    ST_ARB
  } state_t;

  state_t                state_q, state_d;
  logic [4:0]            init_idx_q, init_idx_d;
  logic                  we_q, we_d;
  logic [4:0]            wreg_q, wreg_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  last_q, last_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  logic                  grant_valid;
  logic                  grant;
  logic [4:0]            sel_reg;
  logic [31:0]           sel_data;

  // State register; reset picks the start state from INIT_ENABLE
  always_ff @(posedge clock) begin
    if (reset) state_q <= INIT_ENABLE ? ST_INIT : ST_ARB;
    else       state_q <= state_d;
  end

  // Next state: leave INIT on the edge that writes r31
  always_comb begin
    state_d = state_q;
    if (state_q == ST_INIT && init_idx_q == 5'd31) state_d = ST_ARB;
  end

  // Round-robin grant; gated by reset so a reset-cycle request is never acknowledged
  always_comb begin
    grant_valid = 1'b0;
    grant       = 1'b0;
    if (state_q == ST_ARB && !reset) begin
      if (bus.i_req0_valid && bus.i_req1_valid) begin
        grant_valid = 1'b1;
        grant       = ~last_q;
      end else if (bus.i_req0_valid) begin
        grant_valid = 1'b1;
        grant       = 1'b0;
      end else if (bus.i_req1_valid) begin
        grant_valid = 1'b1;
        grant       = 1'b1;
      end
    end
    sel_reg  = grant ? bus.i_req1_reg  : bus.i_req0_reg;
    sel_data = grant ? bus.i_req1_data : bus.i_req0_data;
  end

  // Write-port, init counter, last-grant and drop-counter next values
  always_comb begin
    init_idx_d = init_idx_q;
    we_d       = 1'b0;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    last_d     = last_q;
    drop_d     = drop_q;
    if (state_q == ST_INIT) begin
      we_d       = 1'b1;
      wreg_d     = init_idx_q;
      wdata_d    = INIT_VALUE;
      init_idx_d = init_idx_q + 5'd1;
    end else if (grant_valid) begin
      last_d = grant;
      if (sel_reg != 5'd0) begin
        we_d    = 1'b1;
        wreg_d  = sel_reg;
        wdata_d = sel_data;
      end else if (drop_q != '1) begin
        drop_d = drop_q + DROP_CNT_W'(1);
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      init_idx_q <= 5'd1;
      we_q       <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
      last_q     <= 1'b1;
      drop_q     <= '0;
    end else begin
      init_idx_q <= init_idx_d;
      we_q       <= we_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
      last_q     <= last_d;
      drop_q     <= drop_d;
    end
  end

  // Outputs
  always_comb begin
    bus.o_req0_ready   = grant_valid && !grant;
    bus.o_req1_ready   = grant_valid &&  grant;
    bus.o_write_enable = we_q;
    bus.o_write_reg    = wreg_q;
    bus.o_write_data   = wdata_q;
    bus.o_init_busy    = (state_q == ST_INIT);
    bus.o_last_grant   = last_q;
    bus.o_drop_count   = drop_q;
  end

endmodule

// File: tb/tb_gpr_write_arbiter.sv
// Randomized bench for gpr_write_arbiter: two instances (init enabled with a
// 2-bit drop counter, init disabled with an 8-bit one) driven by independent
// requester agents and checked every cycle against a behavioural model.
module tb_gpr_write_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  gpr_write_arbiter_if #(.DROP_CNT_W(2)) if_a ();
  gpr_write_arbiter_if #(.DROP_CNT_W(8)) if_b ();

  logic        rst [2];
  logic        v0 [2], v1 [2];
  logic [4:0]  r0 [2], r1 [2];
  logic [31:0] d0 [2], d1 [2];

  gpr_write_arbiter #(.INIT_ENABLE(1'b1), .INIT_VALUE(32'hDEADBEEF), .DROP_CNT_W(2))
    dut_a (.clock(clock), .reset(rst[0]), .bus(if_a));
  gpr_write_arbiter #(.INIT_ENABLE(1'b0), .INIT_VALUE(32'hA5A5A5A5), .DROP_CNT_W(8))
    dut_b (.clock(clock), .reset(rst[1]), .bus(if_b));

  assign if_a.i_req0_valid = v0[0];
  assign if_a.i_req0_reg   = r0[0];
  assign if_a.i_req0_data  = d0[0];
  assign if_a.i_req1_valid = v1[0];
  assign if_a.i_req1_reg   = r1[0];
  assign if_a.i_req1_data  = d1[0];
  assign if_b.i_req0_valid = v0[1];
  assign if_b.i_req0_reg   = r0[1];
  assign if_b.i_req0_data  = d0[1];
  assign if_b.i_req1_valid = v1[1];
  assign if_b.i_req1_reg   = r1[1];
  assign if_b.i_req1_data  = d1[1];

  logic        o_rdy0 [2], o_rdy1 [2], o_we [2], o_busy [2], o_last [2];
  logic [4:0]  o_reg [2];
  logic [31:0] o_data [2];
  logic [7:0]  o_drop [2];

  assign o_rdy0[0] = if_a.o_req0_ready;   assign o_rdy0[1] = if_b.o_req0_ready;
  assign o_rdy1[0] = if_a.o_req1_ready;   assign o_rdy1[1] = if_b.o_req1_ready;
  assign o_we[0]   = if_a.o_write_enable; assign o_we[1]   = if_b.o_write_enable;
  assign o_reg[0]  = if_a.o_write_reg;    assign o_reg[1]  = if_b.o_write_reg;
  assign o_data[0] = if_a.o_write_data;   assign o_data[1] = if_b.o_write_data;
  assign o_busy[0] = if_a.o_init_busy;    assign o_busy[1] = if_b.o_init_busy;
  assign o_last[0] = if_a.o_last_grant;   assign o_last[1] = if_b.o_last_grant;
  assign o_drop[0] = {6'b0, if_a.o_drop_count};
  assign o_drop[1] = if_b.o_drop_count;

  // Per-instance configuration as seen by the model
  bit          cfg_init [2] = '{1'b1, 1'b0};
  logic [31:0] cfg_val  [2] = '{32'hDEADBEEF, 32'hA5A5A5A5};
  int          cfg_max  [2] = '{3, 255};

  // Behavioural model state
  bit          m_init [2];
  int          m_idx  [2];
  int          m_last [2];
  bit          m_we   [2];
  int          m_reg  [2];
  logic [31:0] m_data [2];
  int          m_drop [2];

  // Requester agents: pending write per requester, held until accepted
  bit          p_v [2][2];
  logic [4:0]  p_r [2][2];
  logic [31:0] p_d [2][2];

  int n_tests = 0;
  int n_fail  = 0;
  bit did_mid_reset = 1'b0;
  int init_writes_seen = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Build next cycle's requests for instance k
  task automatic drive_agents(input int k);
    for (int j = 0; j < 2; j++) begin
      if (!p_v[k][j]) begin
        if ($urandom_range(0, 9) < 7) begin
          p_v[k][j] = 1'b1;
          p_r[k][j] = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          p_d[k][j] = $urandom;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        p_v[k][j] = 1'b0;  // withdrawn without acceptance
      end
    end
    v0[k] = p_v[k][0];
    v1[k] = p_v[k][1];
    r0[k] = p_v[k][0] ? p_r[k][0] : 5'($urandom);
    r1[k] = p_v[k][1] ? p_r[k][1] : 5'($urandom);
    d0[k] = p_v[k][0] ? p_d[k][0] : $urandom;  // garbage when idle
    d1[k] = p_v[k][1] ? p_d[k][1] : $urandom;
  endtask

  // One clock: drive at negedge, check readies, advance model, check outputs
  task automatic run_cycle();
    int g [2];
    for (int k = 0; k < 2; k++) drive_agents(k);
    #1;
    for (int k = 0; k < 2; k++) begin
      g[k] = -1;
      if (!rst[k] && !m_init[k]) begin
        if (v0[k] && v1[k]) g[k] = 1 - m_last[k];
        else if (v0[k])     g[k] = 0;
        else if (v1[k])     g[k] = 1;
      end
      check_eq($sformatf("ready0[%0d]", k), 32'(o_rdy0[k]), 32'(g[k] == 0));
      check_eq($sformatf("ready1[%0d]", k), 32'(o_rdy1[k]), 32'(g[k] == 1));
      if (rst[k]) begin
        m_init[k] = cfg_init[k];
        m_idx[k]  = 1;
        m_we[k]   = 1'b0;
        m_reg[k]  = 0;
        m_data[k] = '0;
        m_last[k] = 1;
        m_drop[k] = 0;
      end else if (m_init[k]) begin
        m_we[k]   = 1'b1;
        m_reg[k]  = m_idx[k];
        m_data[k] = cfg_val[k];
        if (m_idx[k] == 31) m_init[k] = 1'b0;
        m_idx[k]  = (m_idx[k] + 1) % 32;
      end else if (g[k] >= 0) begin
        m_last[k] = g[k];
        if (p_r[k][g[k]] != 0) begin
          m_we[k]   = 1'b1;
          m_reg[k]  = p_r[k][g[k]];
          m_data[k] = p_d[k][g[k]];
        end else begin
          m_we[k]   = 1'b0;
          if (m_drop[k] < cfg_max[k]) m_drop[k]++;
        end
        p_v[k][g[k]] = 1'b0;
      end else begin
        m_we[k] = 1'b0;
      end
    end
    @(posedge clock);
    #1;
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("we[%0d]", k),   32'(o_we[k]),   32'(m_we[k]));
      check_eq($sformatf("reg[%0d]", k),  32'(o_reg[k]),  32'(m_reg[k]));
      check_eq($sformatf("data[%0d]", k), o_data[k],      m_data[k]);
      check_eq($sformatf("busy[%0d]", k), 32'(o_busy[k]), 32'(m_init[k]));
      check_eq($sformatf("last[%0d]", k), 32'(o_last[k]), 32'(m_last[k]));
      check_eq($sformatf("drop[%0d]", k), 32'(o_drop[k]), 32'(m_drop[k]));
    end
    if (o_we[0] && o_busy[0] !== 1'b0 && o_data[0] == 32'hDEADBEEF) init_writes_seen++;
    @(negedge clock);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1;
      v0[k] = 1'b0; v1[k] = 1'b0;
      r0[k] = '0;   r1[k] = '0;
      d0[k] = '0;   d1[k] = '0;
      m_init[k] = cfg_init[k]; m_idx[k] = 1; m_last[k] = 1;
      m_we[k] = 1'b0; m_reg[k] = 0; m_data[k] = '0; m_drop[k] = 0;
      for (int j = 0; j < 2; j++) begin
        p_v[k][j] = 1'b0; p_r[k][j] = '0; p_d[k][j] = '0;
      end
    end
    // Instance b gets a pending req0 so its first post-reset cycle accepts
    p_v[1][0] = 1'b1; p_r[1][0] = 5'd7; p_d[1][0] = 32'hCAFE0007;
    @(negedge clock);
    run_cycle();
    run_cycle();
    for (int k = 0; k < 2; k++) rst[k] = 1'b0;

    for (int c = 0; c < 1500; c++) begin
      // One-cycle reset while instance a's init counter sits at 10
      rst[0] = 1'b0;
      rst[1] = ($urandom_range(0, 199) == 0);
      if (!did_mid_reset && m_init[0] && m_idx[0] == 10) begin
        rst[0] = 1'b1;
        did_mid_reset = 1'b1;
      end else if (did_mid_reset && $urandom_range(0, 299) == 0) begin
        rst[0] = 1'b1;
      end
      run_cycle();
    end

    check_eq("mid_init_reset_hit", 32'(did_mid_reset), 32'd1);
    check_eq("init_writes_total_ge_40", 32'(init_writes_seen >= 40), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
